router_pkt_tx: RTL and testbench

Packet source for the 1x3 router's input port. It accepts a packet command (destination address plus payload length), buffers the payload bytes, and then drives the router's byte-serial input stream. The stream is a header byte, then the payload, then a parity byte, with `packet_valid` framing and `busy` back-pressure. It sits between a host/DMA-side byte stream and the router's `data_in`/`packet_valid`/`busy`/`err` pins, and reports the router's parity verdict back to the host.

---
 rtl/router_pkg.sv | 31 +++
 rtl/router_tx_buf.sv | 36 +++
 rtl/router_pkt_tx.sv | 155 +++++++++++++++
 tb/tb_router_pkt_tx.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/router_pkg.sv
`default_nettype none
// ============================================================================
// Module   : router_pkg
// Purpose  : Shared types and constants for the router packet source:
//            transmit state enum, illegal address code, maximum payload
//            length and the header packing helper.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package router_pkg;

  localparam int         MAX_LEN      = 63;
  localparam logic [1:0] ADDR_ILLEGAL = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LOAD    = 3'd1,
    S_HEADER  = 3'd2,
    S_PAYLOAD = 3'd3,
    S_PARITY  = 3'd4,
    S_CHECK   = 3'd5
  } tx_state_t;

  // Router header byte: payload length in the upper six bits, port below.
  function automatic logic [7:0] pack_header(input logic [5:0] len,
                                             input logic [1:0] addr);
    return {len, addr};
  endfunction

endpackage
`default_nettype wire

// File: rtl/router_tx_buf.sv
`default_nettype none
// ============================================================================
// Module   : router_tx_buf
// Purpose  : Payload store, one synchronous write port and one asynchronous
//            read port, holding a whole packet before it is framed out.
// Ports    : clk      - clock
//            wr_en    - write strobe
//            wr_addr  - write index
//            wr_data  - write byte
//            rd_addr  - read index
//            rd_data  - byte at rd_addr
// Revision : 1.0 - initial release
// ============================================================================
module router_tx_buf #(
  parameter int DEPTH = 64,
  parameter int AW    = 6
) (
  input  logic          clk,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [7:0]    wr_data,
  input  logic [AW-1:0] rd_addr,
  output logic [7:0]    rd_data
);

  // Contents need no reset: every byte is written before it is read.
  logic [7:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  assign rd_data = mem[rd_addr];

endmodule
`default_nettype wire

// File: rtl/router_pkt_tx.sv
`default_nettype none
// ============================================================================
// Module   : router_pkt_tx
// Purpose  : Packet source for the 1x3 router input port. Accepts a command
//            (address + length), buffers the payload, then sends header,
//            payload and parity honouring busy, and reports the router's
//            parity verdict.
// Ports    : clk, reset                 - clock, sync active-high reset
//            cmd_valid/ready/addr/len   - packet command handshake
//            pl_valid/ready/data        - payload byte handshake
//            busy, err                  - router back-pressure / error flag
//            packet_valid, pkt_data     - byte stream toward the router
//            cmd_err                    - pulse: command rejected
//            tx_done, done_err          - pulse: packet finished + status
// Revision : 1.0 - initial release
// ============================================================================
module router_pkt_tx
  import router_pkg::*;
#(
  parameter int MAX_LEN = router_pkg::MAX_LEN
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_addr,
  input  logic [5:0] cmd_len,
  input  logic       pl_valid,
  output logic       pl_ready,
  input  logic [7:0] pl_data,
  input  logic       busy,
  input  logic       err,
  output logic       packet_valid,
  output logic [7:0] pkt_data,
  output logic       cmd_err,
  output logic       tx_done,
  output logic       done_err
);

  tx_state_t  state;
  logic [7:0] header;
  logic [5:0] len;
  logic [7:0] parity;
  logic [5:0] cnt;
  logic [5:0] idx;
  logic       chk_phase;
  logic       err_latch;
  logic [7:0] rd_data;
  logic       wr_en;

  assign wr_en = (state == S_LOAD) && pl_valid;

  router_tx_buf #(
    .DEPTH (MAX_LEN + 1),
    .AW    (6)
  ) u_buf (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_addr (cnt),
    .wr_data (pl_data),
    .rd_addr (idx),
    .rd_data (rd_data)
  );

  // Stream outputs decode only from registered state, so they stay
  // constant while busy stalls the state machine.
  assign cmd_ready    = (state == S_IDLE);
  assign pl_ready     = (state == S_LOAD);
  assign packet_valid = (state == S_HEADER) || (state == S_PAYLOAD);

  always_comb begin
    pkt_data = 8'h00;
    case (state)
      S_HEADER:  pkt_data = header;
      S_PAYLOAD: pkt_data = rd_data;
      S_PARITY:  pkt_data = parity;
      default:   pkt_data = 8'h00;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      header    <= 8'h00;
      len       <= 6'd0;
      parity    <= 8'h00;
      cnt       <= 6'd0;
      idx       <= 6'd0;
      chk_phase <= 1'b0;
      err_latch <= 1'b0;
      cmd_err   <= 1'b0;
      tx_done   <= 1'b0;
      done_err  <= 1'b0;
    end else begin
      cmd_err  <= 1'b0;
      tx_done  <= 1'b0;
      done_err <= 1'b0;
      case (state)
        S_IDLE: begin
          if (cmd_valid) begin
            if (cmd_addr == ADDR_ILLEGAL) begin
              cmd_err <= 1'b1;
            end else begin
              header <= pack_header(cmd_len, cmd_addr);
              parity <= pack_header(cmd_len, cmd_addr);
              len    <= cmd_len;
              cnt    <= 6'd0;
              state  <= (cmd_len == 6'd0) ? S_HEADER : S_LOAD;
            end
          end
        end
        S_LOAD: begin
          if (pl_valid) begin
            parity <= parity ^ pl_data;
            cnt    <= cnt + 6'd1;
            if (cnt == len - 6'd1) state <= S_HEADER;
          end
        end
        S_HEADER: begin
          if (!busy) begin
            idx   <= 6'd0;
            state <= (len == 6'd0) ? S_PARITY : S_PAYLOAD;
          end
        end
        S_PAYLOAD: begin
          if (!busy) begin
            if (idx == len - 6'd1) state <= S_PARITY;
            else                   idx   <= idx + 6'd1;
          end
        end
        S_PARITY: begin
          if (!busy) begin
            chk_phase <= 1'b0;
            err_latch <= 1'b0;
            state     <= S_CHECK;
          end
        end
        S_CHECK: begin
          // Second cycle folds in the current err so a late flag is kept.
          if (!chk_phase) begin
            err_latch <= err_latch | err;
            chk_phase <= 1'b1;
          end else begin
            done_err <= err_latch | err;
            tx_done  <= 1'b1;
            state    <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_router_pkt_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_router_pkt_tx
// Purpose  : Self-checking bench for router_pkt_tx: directed table of
//            packets plus randomized packets against a stream-level model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_router_pkt_tx;

  logic       clk = 1'b0;
  logic       reset;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_addr;
  logic [5:0] cmd_len;
  logic       pl_valid;
  logic       pl_ready;
  logic [7:0] pl_data;
  logic       busy;
  logic       err;
  logic       packet_valid;
  logic [7:0] pkt_data;
  logic       cmd_err;
  logic       tx_done;
  logic       done_err;

  always #5 clk = ~clk;

  router_pkt_tx dut (
    .clk          (clk),
    .reset        (reset),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_addr     (cmd_addr),
    .cmd_len      (cmd_len),
    .pl_valid     (pl_valid),
    .pl_ready     (pl_ready),
    .pl_data      (pl_data),
    .busy         (busy),
    .err          (err),
    .packet_valid (packet_valid),
    .pkt_data     (pkt_data),
    .cmd_err      (cmd_err),
    .tx_done      (tx_done),
    .done_err     (done_err)
  );

  int vectors     = 0;
  int miscompares = 0;

  logic [7:0] pl [64];

  typedef struct {
    logic [1:0] addr;
    logic [5:0] len;
    int         busy_mode;   // 0 none, 1 random, 2 three-cycle hold at busy_k
    int         busy_k;
    bit         e1;
    bit         e2;
    logic [7:0] hdr;
    logic [7:0] par;
    bit         cerr;
    bit         derr;
    int         rst_k;       // stream position to reset at, -1 for none
  } vec_t;

  vec_t tbl [9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference parity: header XOR every payload byte.
  function automatic logic [7:0] model_parity(input logic [1:0] addr, input logic [5:0] len);
    logic [7:0] p;
    p = {len, addr};
    for (int i = 0; i < int'(len); i++) p ^= pl[i];
    return p;
  endfunction

  // Called at a negedge with the DUT idle; returns at a negedge.
  task automatic run_pkt(input vec_t v);
    logic [7:0] stream [$];
    int   k, i, hold, guard;
    bit   pv, b;
    chk("cmd_ready idle", cmd_ready, 1);
    cmd_valid = 1'b1; cmd_addr = v.addr; cmd_len = v.len;
    @(negedge clk);
    cmd_valid = 1'b0;
    if (v.cerr) begin
      chk("cmd_err pulse", cmd_err, 1);
      chk("pv after illegal", packet_valid, 0);
      chk("cmd_ready after illegal", cmd_ready, 1);
      @(negedge clk);
      chk("cmd_err single", cmd_err, 0);
      chk("pv stays low", packet_valid, 0);
      chk("cmd_ready stays", cmd_ready, 1);
      return;
    end
    stream.push_back(v.hdr);
    for (int j = 0; j < int'(v.len); j++) stream.push_back(pl[j]);
    stream.push_back(v.par);

    i = 0;
    while (i < int'(v.len)) begin
      chk("pl_ready load", pl_ready, 1);
      chk("pv load", packet_valid, 0);
      pv = ($urandom_range(0, 3) != 0);
      pl_valid = pv;
      pl_data  = pv ? pl[i] : 8'($urandom);
      @(negedge clk);
      if (pv) i++;
    end
    pl_valid = 1'b0;
    chk("pl_ready after load", pl_ready, 0);

    k = 0; hold = 0; guard = 0;
    while (k < int'(v.len) + 2) begin
      chk("pv stream", packet_valid, (k <= int'(v.len)));
      chk("pkt_data stream", pkt_data, stream[k]);
      chk("cmd_ready busy tx", cmd_ready, 0);
      chk("cmd_err ignored", cmd_err, 0);
      if (k == v.rst_k) begin
        reset = 1'b1; cmd_valid = 1'b0; pl_valid = 1'b0; busy = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        chk("pv after reset", packet_valid, 0);
        chk("cmd_ready after reset", cmd_ready, 1);
        chk("pkt_data after reset", pkt_data, 0);
        chk("tx_done after reset", tx_done, 0);
        repeat (4) begin
          @(negedge clk);
          chk("no tx_done after reset", tx_done, 0);
        end
        return;
      end
      case (v.busy_mode)
        1:       b = ($urandom_range(0, 2) == 0);
        2:       b = (k == v.busy_k) && (hold < 3);
        default: b = 1'b0;
      endcase
      if (b) hold++;
      busy      = b;
      cmd_valid = 1'($urandom_range(0, 1));
      cmd_addr  = 2'($urandom_range(0, 3));
      pl_valid  = 1'($urandom_range(0, 1));
      pl_data   = 8'($urandom);
      @(negedge clk);
      if (!b) k++;
      guard++;
      if (guard > 2000) begin
        chk("stream timeout", 0, 1);
        busy = 1'b0; cmd_valid = 1'b0; pl_valid = 1'b0;
        return;
      end
    end
    busy = 1'b0; cmd_valid = 1'b0; pl_valid = 1'b0;

    chk("check1 pkt_data", pkt_data, 0);
    chk("check1 pv", packet_valid, 0);
    chk("check1 tx_done", tx_done, 0);
    err = v.e1;
    @(negedge clk);
    chk("check2 pkt_data", pkt_data, 0);
    chk("check2 tx_done", tx_done, 0);
    err = v.e2;
    @(negedge clk);
    err = 1'b0;
    chk("tx_done pulse", tx_done, 1);
    chk("done_err", done_err, v.derr);
    chk("cmd_ready after done", cmd_ready, 1);
    @(negedge clk);
    chk("tx_done single", tx_done, 0);
    chk("done_err cleared", done_err, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vec_t r;
    int   sel;
    reset = 1'b1; cmd_valid = 1'b0; cmd_addr = 2'd0; cmd_len = 6'd0;
    pl_valid = 1'b0; pl_data = 8'h00; busy = 1'b0; err = 1'b0;

    tbl[0] = '{2'd2, 6'd5,  0, 0, 1'b0, 1'b0, 8'h16, 8'h17, 1'b0, 1'b0, -1};
    tbl[1] = '{2'd1, 6'd0,  0, 0, 1'b0, 1'b0, 8'h01, 8'h01, 1'b0, 1'b0, -1};
    tbl[2] = '{2'd3, 6'd4,  0, 0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, -1};
    tbl[3] = '{2'd2, 6'd5,  2, 2, 1'b0, 1'b0, 8'h16, 8'h17, 1'b0, 1'b0, -1};
    tbl[4] = '{2'd2, 6'd5,  0, 0, 1'b1, 1'b0, 8'h16, 8'h17, 1'b0, 1'b1, -1};
    tbl[5] = '{2'd0, 6'd5,  0, 0, 1'b0, 1'b1, 8'h14, 8'h15, 1'b0, 1'b1, -1};
    tbl[6] = '{2'd0, 6'd63, 1, 0, 1'b0, 1'b0, 8'hFC, 8'hFC, 1'b0, 1'b0, -1};
    tbl[7] = '{2'd2, 6'd5,  0, 0, 1'b0, 1'b0, 8'h16, 8'h17, 1'b0, 1'b0,  3};
    tbl[8] = '{2'd2, 6'd5,  0, 0, 1'b0, 1'b0, 8'h16, 8'h17, 1'b0, 1'b0, -1};

    repeat (2) @(negedge clk);
    chk("reset packet_valid", packet_valid, 0);
    chk("reset pkt_data", pkt_data, 0);
    chk("reset pl_ready", pl_ready, 0);
    chk("reset cmd_err", cmd_err, 0);
    chk("reset tx_done", tx_done, 0);
    chk("reset done_err", done_err, 0);
    chk("reset cmd_ready", cmd_ready, 1);
    reset = 1'b0;
    @(negedge clk);

    for (int t = 0; t < 9; t++) begin
      for (int j = 0; j < 64; j++) pl[j] = 8'(j + 1);
      run_pkt(tbl[t]);
    end

    for (int n = 0; n < 40; n++) begin
      sel = int'($urandom_range(0, 9));
      r.addr = 2'($urandom_range(0, 3));
      r.len  = (sel == 0) ? 6'd0 : (sel == 1) ? 6'd63 : 6'($urandom_range(1, 62));
      for (int j = 0; j < 64; j++) pl[j] = 8'($urandom);
      r.busy_mode = 1; r.busy_k = 0;
      r.e1 = 1'($urandom_range(0, 1)); r.e2 = 1'($urandom_range(0, 1));
      r.hdr  = {r.len, r.addr};
      r.par  = model_parity(r.addr, r.len);
      r.cerr = (r.addr == 2'd3);
      r.derr = r.e1 | r.e2;
      r.rst_k = -1;
      run_pkt(r);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
